// File: rtl/obi_bram_responder.sv
`default_nettype none
// ============================================================================
// Module      : obi_bram_responder
// Description : OBI slave that maps a byte-address window onto a dual-port
//               block RAM, with in-order responses and access counters.
// Revision    : 1.0 - initial release
// ============================================================================
module obi_bram_responder #(
    parameter int          ADDR_WIDTH      = 17,
    parameter              RAM_PERFORMANCE = "LOW_LATENCY",
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
    output logic                  gnt_o,
    input  logic [31:0]           addr_i,
    input  logic                  we_i,
    input  logic [3:0]            be_i,
    input  logic [31:0]           wdata_i,
    output logic                  rvalid_o,
    output logic [31:0]           rdata_o,
    output logic                  err_o,
    output logic [ADDR_WIDTH-1:0] ram_addra_o,
    output logic [3:0]            ram_wea_o,
    output logic [31:0]           ram_dina_o,
    output logic [ADDR_WIDTH-1:0] ram_addrb_o,
    output logic                  ram_enb_o,
    output logic                  ram_regceb_o,
    output logic                  ram_rstb_o,
    input  logic [31:0]           ram_doutb_i,
    input  logic                  cnt_clr_i,
    output logic [31:0]           rd_cnt_o,
    output logic [31:0]           wr_cnt_o,
    output logic                  err_sticky_o
);

    localparam int          c_LAT  = (RAM_PERFORMANCE == "HIGH_PERFORMANCE") ? 2 : 1;
    // 33 bits so the window size cannot wrap for wide RAMs
    localparam logic [32:0] c_SPAN = 33'd1 << (ADDR_WIDTH + 2);

    logic [31:0]           w_offset;
    logic                  w_in_range;
    logic [ADDR_WIDTH-1:0] w_word;
    logic                  w_acc;
    logic                  w_wr;
    logic                  w_rd;
    logic                  w_oor;

    logic [c_LAT-1:0]      r_vld;
    logic [c_LAT-1:0]      r_rd;
    logic [c_LAT-1:0]      r_err;
    logic [31:0]           r_rd_cnt;
    logic [31:0]           r_wr_cnt;
    logic                  r_err_sticky;

    assign w_offset   = addr_i - BASE_ADDR;
    assign w_in_range = ({1'b0, w_offset} < c_SPAN);
    assign w_word     = w_offset[ADDR_WIDTH+1:2];

    assign gnt_o = req_i & ~rst_i;
    assign w_acc = req_i & gnt_o;
    assign w_wr  = w_acc & we_i & w_in_range;
    assign w_rd  = w_acc & ~we_i & w_in_range;
    assign w_oor = w_acc & ~w_in_range;

    assign ram_addra_o = w_word;
    assign ram_wea_o   = w_wr ? be_i : 4'h0;
    assign ram_dina_o  = wdata_i;
    assign ram_addrb_o = w_word;
    assign ram_enb_o   = w_rd;
    assign ram_rstb_o  = rst_i;

    // Response pipeline: depth matches the RAM read latency
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_vld <= '0;
            r_rd  <= '0;
            r_err <= '0;
        end else begin
            r_vld[0] <= w_acc;
            r_rd[0]  <= w_rd;
            r_err[0] <= w_oor;
            for (int i = 1; i < c_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_rd[i]  <= r_rd[i-1];
                r_err[i] <= r_err[i-1];
            end
        end
    end

    assign rvalid_o = r_vld[c_LAT-1];
    assign err_o    = r_vld[c_LAT-1] & r_err[c_LAT-1];
    assign rdata_o  = (r_vld[c_LAT-1] & r_rd[c_LAT-1]) ? ram_doutb_i : 32'h0;

    generate
        if (c_LAT == 2) begin : g_regce_hp
            assign ram_regceb_o = r_vld[0] & r_rd[0];
        end else begin : g_regce_ll
            assign ram_regceb_o = 1'b0;
        end
    endgenerate

    // Clear wins over any same-cycle increment or error capture
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rd_cnt     <= 32'h0;
            r_wr_cnt     <= 32'h0;
            r_err_sticky <= 1'b0;
        end else if (cnt_clr_i) begin
            r_rd_cnt     <= 32'h0;
            r_wr_cnt     <= 32'h0;
            r_err_sticky <= 1'b0;
        end else begin
            if (w_rd && (r_rd_cnt != 32'hFFFF_FFFF)) begin
                r_rd_cnt <= r_rd_cnt + 32'd1;
            end
            if (w_wr && (r_wr_cnt != 32'hFFFF_FFFF)) begin
                r_wr_cnt <= r_wr_cnt + 32'd1;
            end
            if (w_oor) begin
                r_err_sticky <= 1'b1;
            end
        end
    end

    assign rd_cnt_o     = r_rd_cnt;
    assign wr_cnt_o     = r_wr_cnt;
    assign err_sticky_o = r_err_sticky;

endmodule
`default_nettype wire
